// File: rtl/ssd_pkg.sv
// Segment-pattern constants, the digit-slot record and capture states for the
// seven-segment readback path. Shared with the board-side encoder.
package ssd_pkg;

  // Active-high, abcdefg order, indexed by hex value.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  localparam logic [6:0] BLANK_PATTERN = 7'b0000000;

  typedef struct packed {
    logic [3:0] value;
    logic       ok;
    logic       blank;
  } digit_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_HELD
  } cap_state_t;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational seven-segment pattern to hex decode; no latency, no flow control.
// Unrecognised patterns decode to value 0 with ok and blank both low.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0]  seg,
  output digit_slot_t slot
);

  always_comb begin
    slot = '0;
    if (seg == BLANK_PATTERN) begin
      slot.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_HEX[i]) begin
          slot.value = 4'(i);
          slot.ok    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ssd_scan_capture.sv
// Samples a multiplexed 4-digit seven-segment display and publishes decoded frames.
// Digit capture SETTLE+1 cycles after inputs settle; frame_valid one cycle after last capture.
module ssd_scan_capture
  import ssd_pkg::*;
#(
  parameter int unsigned SETTLE         = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       an0,
  input  logic       an1,
  input  logic       an2,
  input  logic       an3,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_ok,
  output logic [3:0] digit_blank,
  output logic       frame_valid,
  output logic       overlap_err
);

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  logic [6:0]        seg_raw;
  logic [3:0]        an_raw;
  logic [10:0]       r_d, r_q, r_prev_q;
  logic [7:0]        cnt_d, cnt_q;
  cap_state_t        state_d, state_q;
  digit_slot_t [3:0] slot_d, slot_q;
  digit_slot_t [3:0] out_d, out_q;
  logic [3:0]        mask_d, mask_q;
  logic              frame_valid_d, frame_valid_q;
  logic              overlap_err_d, overlap_err_q;

  logic [6:0]  seg_q;
  logic [3:0]  an_q;
  logic        same, one_hot, multi, multi_prev, capture, frame_done;
  digit_slot_t dec;

  assign seg_raw = {a, b, c, d, e, f, g};
  assign an_raw  = {an3, an2, an1, an0};
  assign seg_q   = r_q[10:4];
  assign an_q    = r_q[3:0];

  ssd_seg_decode u_dec (
    .seg  (seg_q),
    .slot (dec)
  );

  always_comb begin
    r_d        = {SEG_ACTIVE_LOW ? ~seg_raw : seg_raw, AN_ACTIVE_LOW ? ~an_raw : an_raw};
    same       = (r_q == r_prev_q);
    one_hot    = $onehot(an_q);
    multi      = $countones(an_q) > 1;
    multi_prev = $countones(r_prev_q[3:0]) > 1;

    if (!same)                 cnt_d = '0;
    else if (cnt_q == SETTLE_C) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 8'd1;

    // cnt_q reaches SETTLE-1 only once per stable run, so capture fires at most once.
    capture = (state_q == ST_SETTLING) && one_hot && same && (cnt_q == SETTLE_M1);

    if (!one_hot)                 state_d = ST_IDLE;
    else if (!same)               state_d = ST_SETTLING;
    else if (capture)             state_d = ST_HELD;
    else if (state_q == ST_IDLE)  state_d = ST_SETTLING;
    else                          state_d = state_q;

    overlap_err_d = multi && !multi_prev;

    frame_done    = (mask_q == 4'b1111);
    frame_valid_d = frame_done;
    out_d         = frame_done ? slot_q : out_q;
    mask_d        = frame_done ? 4'b0000 : mask_q;
    slot_d        = slot_q;
    if (capture) begin
      for (int k = 0; k < 4; k++) begin
        if (an_q[k]) begin
          slot_d[k] = dec;
          mask_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q           <= '0;
      r_prev_q      <= '0;
      cnt_q         <= '0;
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      mask_q        <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      overlap_err_q <= 1'b0;
    end else begin
      r_q           <= r_d;
      r_prev_q      <= r_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      slot_q        <= slot_d;
      mask_q        <= mask_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      overlap_err_q <= overlap_err_d;
    end
  end

  assign digit0      = out_q[0].value;
  assign digit1      = out_q[1].value;
  assign digit2      = out_q[2].value;
  assign digit3      = out_q[3].value;
  assign digit_ok    = {out_q[3].ok, out_q[2].ok, out_q[1].ok, out_q[0].ok};
  assign digit_blank = {out_q[3].blank, out_q[2].blank, out_q[1].blank, out_q[0].blank};
  assign frame_valid = frame_valid_q;
  assign overlap_err = overlap_err_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Bench for ssd_scan_capture: directed scenarios plus random scans against a
// run-length reference model of the display readback.
module tb_ssd_scan_capture;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       a, b, c, d, e, f, g;
  logic       an0, an1, an2, an3;
  logic [3:0] digit0, digit1, digit2, digit3, digit_ok, digit_blank;
  logic       frame_valid, overlap_err;

  always #5 clk = ~clk;

  ssd_scan_capture #(.SETTLE(SETTLE), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit_ok(digit_ok), .digit_blank(digit_blank),
    .frame_valid(frame_valid), .overlap_err(overlap_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [6:0] hex_pat [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // {value[3:0], ok, blank}
  function automatic logic [5:0] ref_decode(input logic [6:0] s);
    if (s == 7'b0) return 6'b000001;
    for (int i = 0; i < 16; i++)
      if (s == hex_pat[i]) return {4'(i), 2'b10};
    return 6'b000000;
  endfunction

  logic [10:0] m_prev;
  int          m_run;
  bit          cap_next, ov_next, frame_next;
  int          cap_k;
  logic [6:0]  cap_seg;
  logic [5:0]  m_slot [4];
  logic [3:0]  m_mask;
  logic [23:0] m_out;
  int          n_fv, n_ov;

  function automatic logic [23:0] dut_out();
    return {digit3, digit2, digit1, digit0, digit_ok, digit_blank};
  endfunction

  function automatic logic [23:0] slots_packed();
    logic [23:0] v;
    v[23:8] = {m_slot[3][5:2], m_slot[2][5:2], m_slot[1][5:2], m_slot[0][5:2]};
    v[7:4]  = {m_slot[3][1], m_slot[2][1], m_slot[1][1], m_slot[0][1]};
    v[3:0]  = {m_slot[3][0], m_slot[2][0], m_slot[1][0], m_slot[0][0]};
    return v;
  endfunction

  task automatic model_clear();
    m_prev = '0; m_run = 1;
    cap_next = 0; ov_next = 0; frame_next = 0;
    m_mask = '0; m_out = '0;
    for (int i = 0; i < 4; i++) m_slot[i] = '0;
  endtask

  // seg and an are given active-high; the lines are driven active-low.
  task automatic step(input logic [6:0] seg, input logic [3:0] an);
    logic [10:0] v;
    logic        exp_fv, exp_ov;
    {a, b, c, d, e, f, g}  = ~seg;
    {an3, an2, an1, an0}   = ~an;
    @(posedge clk); #1;
    v = {seg, an};
    exp_fv = frame_next;
    frame_next = 0;
    if (exp_fv) begin
      m_out  = slots_packed();
      m_mask = '0;
    end
    if (cap_next) begin
      m_slot[cap_k]  = ref_decode(cap_seg);
      m_mask[cap_k]  = 1'b1;
      if (m_mask == 4'hF) frame_next = 1;
      cap_next = 0;
    end
    exp_ov = ov_next;
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    chk("overlap_err", 32'(overlap_err), 32'(exp_ov));
    chk("outputs", 32'(dut_out()), 32'(m_out));
    if (frame_valid) n_fv++;
    if (overlap_err) n_ov++;
    // A one-anode vector held for SETTLE+1 samples is captured on the next edge.
    m_run = (v == m_prev) ? m_run + 1 : 1;
    if (m_run == SETTLE + 1 && $countones(an) == 1) begin
      cap_next = 1;
      cap_seg  = seg;
      for (int k = 0; k < 4; k++) if (an[k]) cap_k = k;
    end
    ov_next = ($countones(an) > 1) && !($countones(m_prev[3:0]) > 1);
    m_prev  = v;
  endtask

  task automatic hold(input logic [6:0] seg, input logic [3:0] an, input int n);
    repeat (n) step(seg, an);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
    chk("reset_outputs", 32'(dut_out()), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    chk("reset_ov", 32'(overlap_err), 32'h0);
    model_clear();
  endtask

  task automatic scan4(input int v0, input int v1, input int v2, input int v3, input int n);
    hold(hex_pat[v0], 4'b0001, n);
    hold(hex_pat[v1], 4'b0010, n);
    hold(hex_pat[v2], 4'b0100, n);
    hold(hex_pat[v3], 4'b1000, n);
  endtask

  initial begin
    reset = 1'b1;
    {a, b, c, d, e, f, g} = 7'h7F;
    {an3, an2, an1, an0}  = 4'hF;
    model_clear();
    do_reset(2);
    hold(7'b0, 4'b0, 3);

    n_fv = 0;
    scan4(1, 2, 3, 4, 20);
    chk("s1_frames", 32'(n_fv), 32'd1);
    chk("s1_digits", 32'(dut_out()), 32'h4321F0);
    hold(7'b0, 4'b0, 2);

    n_fv = 0;
    hold(hex_pat[8], 4'b0100, 4);
    scan4(5, 6, 7, 9, 10);
    chk("s2_frames", 32'(n_fv), 32'd1);
    chk("s2_digit2", 32'(digit2), 32'd7);
    hold(7'b0, 4'b0, 2);

    hold(hex_pat[1], 4'b0001, 10);
    hold(7'b0000000, 4'b0010, 10);
    hold(hex_pat[2], 4'b0100, 10);
    hold(7'b0000001, 4'b1000, 10);
    chk("s3_blank", 32'(digit_blank), 32'h2);
    chk("s3_ok", 32'(digit_ok), 32'h5);
    chk("s3_digit3", 32'(digit3), 32'h0);
    hold(7'b0, 4'b0, 2);

    n_fv = 0; n_ov = 0;
    hold(hex_pat[6], 4'b0011, 10);
    hold(7'b0, 4'b0, 3);
    chk("s4_overlaps", 32'(n_ov), 32'd1);
    chk("s4_frames", 32'(n_fv), 32'd0);
    chk("s4_hold", 32'(dut_out()), 32'h020152);

    n_fv = 0;
    hold(hex_pat[5], 4'b0001, 10);
    hold(hex_pat[7], 4'b0001, 10);
    hold(hex_pat[1], 4'b0010, 10);
    hold(hex_pat[2], 4'b0100, 10);
    hold(hex_pat[3], 4'b1000, 10);
    chk("s5_frames", 32'(n_fv), 32'd1);
    chk("s5_digits", 32'(dut_out()), 32'h3217F0);
    hold(7'b0, 4'b0, 2);

    n_fv = 0;
    hold(hex_pat[1], 4'b0001, 10);
    hold(hex_pat[2], 4'b0010, 10);
    hold(hex_pat[3], 4'b0100, 10);
    do_reset(1);
    hold(hex_pat[4], 4'b1000, 10);
    chk("s6_frames", 32'(n_fv), 32'd0);
    chk("s6_outputs", 32'(dut_out()), 32'h0);

    for (int it = 0; it < 300; it++) begin
      logic [3:0] an;
      logic [6:0] seg;
      int         r, s;
      r = $urandom_range(0, 9);
      if (r < 8)       an = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) an = 4'b0;
      else             an = 4'($urandom_range(0, 15));
      s = $urandom_range(0, 19);
      if (s < 15)      seg = hex_pat[$urandom_range(0, 15)];
      else if (s < 17) seg = 7'b0;
      else             seg = 7'($urandom);
      hold(seg, an, $urandom_range(1, 12));
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_scan_capture.md
# ssd_scan_capture

Receive-side counterpart of the board's seven-segment multiplexer. It samples the time-multiplexed segment lines (a–g) and anode lines (an0–an3) and waits for each digit's pattern to settle. It then decodes each pattern back to a 4-bit hex value and publishes a complete four-digit frame. It is used in on-board self-check and bench builds to read back what the vending machine is displaying, for example a price or the "delivered" readout.

## Interface

Parameters:
- SETTLE, default 4: number of consecutive identical sampled cycles needed before a digit is captured. Legal range is 2..255.
- SEG_ACTIVE_LOW, default 1: 1 means segment lines are active-low (common anode).
- AN_ACTIVE_LOW, default 1: 1 means anode lines are active-low.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- a, b, c, d, e, f, g  in  1 each  segment lines. Packed internally as seg[6:0] = {a,b,c,d,e,f,g}.
- an0, an1, an2, an3  in  1 each  anode lines. anN selects digit N.
- digit0, digit1, digit2, digit3  out  4 each  decoded hex value of each digit in the last complete frame.
- digit_ok  out  4  bit N = 1 means digitN held a recognised hex pattern.
- digit_blank  out  4  bit N = 1 means digitN had all segments off.
- frame_valid  out  1  one-cycle pulse when the frame outputs update.
- overlap_err  out  1  one-cycle pulse when more than one anode becomes active.

## Operation

- **Input stage:** all 11 inputs are registered once and polarity-normalised to active-high. This gives vector r = {seg, an}. The previous value r_prev is also kept.
- **Stability counter:** cnt saturates at SETTLE.
  - When r == r_prev, cnt increments.
  - Otherwise cnt is cleared to 0.
- **Per-vector state machine**, with states IDLE, SETTLING, HELD:
  - IDLE: no anode is active, or more than one is. cnt is ignored and no capture happens.
  - SETTLING: exactly one anode k is active. When cnt reaches SETTLE-1, the vector is captured into slot[k] and mask[k] is set. Next state is HELD.
  - HELD: no further capture until r changes. Any change in r returns to SETTLING, or to IDLE if the new anode condition requires it.
- **overlap_err:** pulses on the cycle in which the number of active anodes goes from at most one to two or more. It does not repeat while the overlap persists.
- **Segment decode**, with seg written as abcdefg:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
  - All-zero pattern: blank = 1, value 0, ok = 0.
  - Any other pattern: ok = 0, blank = 0, value 0.
- **Recapture:** a digit captured again before the frame completes overwrites slot[k]; the latest capture wins. mask is unchanged.
- **Frame completion:** when mask == 4'b1111 after a capture, on the next edge:
  - digit0..3, digit_ok and digit_blank load from the slots;
  - frame_valid = 1 for that cycle;
  - mask is cleared.
- **Between frames:** outputs hold their values.
- **Reset** clears everything:
  - digit0..3 = 0, digit_ok = 0, digit_blank = 0, frame_valid = 0, overlap_err = 0;
  - mask = 0, cnt = 0, state = IDLE, and the input registers hold the inactive level.
- **Reset during a frame:** the partial mask is discarded. No frame_valid pulse is produced for it.

## Timing

- Inputs are stable from edge E onward, with exactly one anode k active. Then:
  - r is valid after E+1;
  - slot[k] and mask[k] load on edge E+SETTLE+1.
- Fourth-digit capture on edge C: outputs update and frame_valid goes high on edge C+1, so it is observed in cycle C+1.
- A vector shorter than SETTLE+1 cycles is never captured.
- Scan order is irrelevant. Any permutation that covers all four anodes completes a frame.
- frame_valid and overlap_err never stay high for two consecutive cycles.

## Structure

- **Shared package ssd_pkg:**
  - the 16 segment-pattern constants (7-bit, active-high, abcdefg order);
  - BLANK_PATTERN;
  - the digit-slot struct {value[3:0], ok, blank}.
- **Sub-module ssd_seg_decode:** purely combinational, seg[6:0] → {value, ok, blank}. Uses the ssd_pkg constants, and the board-side encoder shares the same constants.
- **Top level:** input register, stability counter, state machine, slot and mask registers, frame register.

## Test plan

- **Full frame, SETTLE = 4, active-low lines:**
  - Stimulus: scan "1", "2", "3", "4" on an0..an3, 20 cycles each.
  - Response: exactly one frame_valid pulse; digit0..3 = 1, 2, 3, 4; digit_ok = 4'b1111; digit_blank = 0.
- **Glitch rejection:**
  - Stimulus: hold an2 with "8" for 4 cycles only (SETTLE = 4), then continue with a full valid scan.
  - Response: the glitch is not captured; the frame holds the scanned values and digit2 is not 8 unless "8" was scanned.
- **Blank and unknown patterns:**
  - Stimulus: an1 = all segments off, an3 = 0000001.
  - Response: digit_blank = 4'b0010, digit_ok[3] = 0, digit3 = 0.
- **Overlap:**
  - Stimulus: an0 and an1 both active for 10 cycles, with the segment pattern held constant.
  - Response: overlap_err pulses once; no capture occurs; mask is unchanged.
- **Recapture before completion:**
  - Stimulus: an0 = "5", then an0 = "7", then an1..an3 valid.
  - Response: digit0 = 7 and one frame_valid pulse.
- **Reset mid-frame:**
  - Stimulus: capture an0..an2, assert reset for one cycle, then capture an3 only.
  - Response: no frame_valid pulse; all outputs stay 0.
